// File: rtl/game_input_ctrl_pkg.sv
// Shared constants, mode encoding and FSM state type for the console input conditioner.
package game_input_pkg;

  localparam int DEB_CYCLES_DEF   = 500000;
  localparam int GUARD_CYCLES_DEF = 1000000;

  localparam logic MODE_PONG   = 1'b0;
  localparam logic MODE_SQUASH = 1'b1;

  typedef enum logic {IDLE, GUARD} mode_state_t;

  // Counter width that stays legal when the terminal count is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_input_ctrl_if.sv
// Raw button/switch inputs and conditioned outputs of the console input block.
interface game_input_ctrl_if #(
  parameter int NKEYS = 4
);
  logic [NKEYS-1:0] KEY;
  logic             mode_sw;
  logic [NKEYS-1:0] key_level;
  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_release;
  logic             game_sel;
  logic             game_restart;
  logic             switching;

  modport slave (
    input  KEY, mode_sw,
    output key_level, key_press, key_release, game_sel, game_restart, switching
  );

  modport master (
    output KEY, mode_sw,
    input  key_level, key_press, key_release, game_sel, game_restart, switching
  );
endinterface

// File: rtl/game_input_ctrl_debounce_bit.sv
// One input bit: 2-flop synchroniser, counter debouncer and registered edge pulses.
module debounce_bit
  import game_input_pkg::*;
#(
  parameter int   DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic RST_VAL    = 1'b0,
  parameter logic INVERT     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic level_next,
  output logic rise,
  output logic fall
);

  localparam int             CW      = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          sample;
  logic          accept;
  logic [CW-1:0] cnt;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  assign sample     = sync_p1 ^ INVERT;
  assign accept     = (sample != level) && (cnt == CNT_MAX);
  // Exposed so a consumer can react on the very edge the new level is accepted.
  assign level_next = accept ? sample : level;

  // Stage debounce: stable level, run counter and edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept & sample;
      fall <= accept & ~sample;
      if (sample == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sample;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_input_ctrl.sv
// Console input conditioner: debounced keys with gated events, plus game-select switch sequencing.
module game_input_ctrl
  import game_input_pkg::*;
#(
  parameter int NKEYS        = 4,
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
  input logic              CLOCK_50,
  input logic              resetn,
  game_input_ctrl_if.slave io
);

  localparam int            GW    = cnt_w(GUARD_CYCLES);
  localparam logic [GW-1:0] G_MAX = GW'(GUARD_CYCLES - 1);

  logic [NKEYS-1:0] key_lvl;
  logic [NKEYS-1:0] press_q;
  logic [NKEYS-1:0] release_q;
  logic [NKEYS-1:0] key_next_unused;
  logic             mode_next;
  logic             mode_level_unused;
  logic             mode_rise_unused;
  logic             mode_fall_unused;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    debounce_bit #(
      .DEB_CYCLES(DEB_CYCLES),
      .RST_VAL   (1'b1),
      .INVERT    (1'b1)
    ) u_deb (
      .clk       (CLOCK_50),
      .rst_n     (resetn),
      .raw       (io.KEY[i]),
      .level     (key_lvl[i]),
      .level_next(key_next_unused[i]),
      .rise      (press_q[i]),
      .fall      (release_q[i])
    );
  end

  debounce_bit #(
    .DEB_CYCLES(DEB_CYCLES),
    .RST_VAL   (MODE_PONG),
    .INVERT    (1'b0)
  ) u_mode (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .raw       (io.mode_sw),
    .level     (mode_level_unused),
    .level_next(mode_next),
    .rise      (mode_rise_unused),
    .fall      (mode_fall_unused)
  );

  mode_state_t   state, state_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic          sel_q, sel_nxt;
  logic          restart_q, restart_nxt;
  logic          switching_q, switching_nxt;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      gcnt        <= '0;
      sel_q       <= MODE_PONG;
      restart_q   <= 1'b0;
      switching_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      gcnt        <= gcnt_nxt;
      sel_q       <= sel_nxt;
      restart_q   <= restart_nxt;
      switching_q <= switching_nxt;
    end
  end

  // The mode compare uses the value being accepted this edge, so selection follows debounce with no extra cycle.
  always_comb begin
    state_nxt     = state;
    gcnt_nxt      = gcnt;
    sel_nxt       = sel_q;
    restart_nxt   = 1'b0;
    switching_nxt = switching_q;
    case (state)
      IDLE: begin
        if (mode_next != sel_q) begin
          sel_nxt       = mode_next;
          restart_nxt   = 1'b1;
          switching_nxt = 1'b1;
          gcnt_nxt      = '0;
          state_nxt     = GUARD;
        end
      end
      GUARD: begin
        if (gcnt == G_MAX) begin
          switching_nxt = 1'b0;
          gcnt_nxt      = '0;
          state_nxt     = IDLE;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign io.key_level    = key_lvl;
  assign io.key_press    = press_q & {NKEYS{~switching_q}};
  assign io.key_release  = release_q & {NKEYS{~switching_q}};
  assign io.game_sel     = sel_q;
  assign io.game_restart = restart_q;
  assign io.switching    = switching_q;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Randomised bench for game_input_ctrl against a sample-window reference model.
module tb_game_input_ctrl;

  localparam int NKEYS = 4;
  localparam int DEB   = 4;
  localparam int GUARD = 8;
  localparam int NB    = NKEYS + 1;
  localparam int NCYC  = 3000;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;

  game_input_ctrl_if #(.NKEYS(NKEYS)) bus ();

  game_input_ctrl #(
    .NKEYS       (NKEYS),
    .DEB_CYCLES  (DEB),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .io      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s at %0t: got %0h, wanted %0h", tag, $time, obs, exp);
    else
      n_pass++;
  endtask

  // Reference model: raw values reach the debouncer two edges late; a new level is
  // accepted once the last DEB samples all disagree with the current level.
  bit m_d1[NB], m_d2[NB];
  bit m_lvl[NB];
  bit m_rise[NB], m_fall[NB];
  bit win[NB][$];
  int m_left;
  bit m_sel, m_restart;

  task model_reset();
    for (int b = 0; b < NB; b++) begin
      m_d1[b]   = (b < NKEYS);
      m_d2[b]   = (b < NKEYS);
      m_lvl[b]  = 1'b0;
      m_rise[b] = 1'b0;
      m_fall[b] = 1'b0;
      win[b].delete();
    end
    m_left    = 0;
    m_sel     = 1'b0;
    m_restart = 1'b0;
  endtask

  task model_step();
    bit raw, samp, all_diff;
    for (int b = 0; b < NB; b++) begin
      raw  = (b < NKEYS) ? bus.KEY[b] : bus.mode_sw;
      samp = (b < NKEYS) ? ~m_d2[b] : m_d2[b];
      m_d2[b] = m_d1[b];
      m_d1[b] = raw;
      win[b].push_back(samp);
      if (win[b].size() > DEB) void'(win[b].pop_front());
      all_diff = (win[b].size() == DEB);
      foreach (win[b][k]) if (win[b][k] == m_lvl[b]) all_diff = 1'b0;
      m_rise[b] = 1'b0;
      m_fall[b] = 1'b0;
      if (all_diff) begin
        m_lvl[b]  = samp;
        m_rise[b] = samp;
        m_fall[b] = ~samp;
      end
    end
    m_restart = 1'b0;
    if (m_left > 0) begin
      m_left--;
    end else if (m_lvl[NKEYS] != m_sel) begin
      m_sel     = m_lvl[NKEYS];
      m_restart = 1'b1;
      m_left    = GUARD;
    end
  endtask

  task compare_all(input string ph);
    logic [NKEYS-1:0] e_lvl, e_prs, e_rel;
    bit sw;
    sw = (m_left > 0);
    for (int b = 0; b < NKEYS; b++) begin
      e_lvl[b] = m_lvl[b];
      e_prs[b] = m_rise[b] & ~sw;
      e_rel[b] = m_fall[b] & ~sw;
    end
    check({ph, " key_level"},    32'(bus.key_level),    32'(e_lvl));
    check({ph, " key_press"},    32'(bus.key_press),    32'(e_prs));
    check({ph, " key_release"},  32'(bus.key_release),  32'(e_rel));
    check({ph, " game_sel"},     32'(bus.game_sel),     32'(m_sel));
    check({ph, " game_restart"}, 32'(bus.game_restart), 32'(m_restart));
    check({ph, " switching"},    32'(bus.switching),    32'(sw));
  endtask

  task apply_reset(input string ph);
    resetn = 1'b0;
    model_reset();
    #1;
    compare_all(ph);
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    compare_all(ph);
    resetn = 1'b1;
  endtask

  int  hold[NB];
  bit  midguard_done;

  initial begin
    bus.KEY     = 4'b0000;
    bus.mode_sw = 1'b1;
    model_reset();
    @(negedge CLOCK_50);
    apply_reset("reset");
    for (int b = 0; b < NB; b++) hold[b] = 8;
    midguard_done = 1'b0;

    for (int i = 0; i < NCYC; i++) begin
      @(posedge CLOCK_50);
      model_step();
      @(negedge CLOCK_50);
      compare_all("run");

      if (!midguard_done && i > 300 && m_left == GUARD - 3) begin
        midguard_done = 1'b1;
        apply_reset("midguard_reset");
      end else if (i == 1000 || i == 2200) begin
        apply_reset("run_reset");
      end

      for (int b = 0; b < NB; b++) begin
        if (hold[b] > 0) hold[b]--;
        if (hold[b] == 0) begin
          if (b < NKEYS) begin
            bus.KEY[b] = 1'($urandom_range(0, 1));
            hold[b]    = $urandom_range(1, 10);
          end else begin
            bus.mode_sw = 1'($urandom_range(0, 1));
            hold[b]     = $urandom_range(1, 40);
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_input_ctrl.md
Name: game_input_ctrl

Overview:
- Input-side conditioner for the game console. It is the counterpart to the output muxing and display path.
- Takes the raw push-buttons and the game-select switch, then synchronises and debounces them.
- Produces clean level signals and one-cycle press/release events for the active game.
- Sequences game switching: selection update, restart pulse, and a guard window during which key events are suppressed.

Parameters:
- NKEYS, 4, number of push-buttons handled.
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a new input level (10 ms at 50 MHz); minimum 2.
- GUARD_CYCLES, 1000000, length of the post-switch event-suppression window in cycles; minimum 1.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- resetn  input  1  asynchronous, active-low reset.
- KEY  input  NKEYS  raw buttons, active-low (0 = pressed), asynchronous to CLOCK_50.
- mode_sw  input  1  raw game-select switch (0 = pong, 1 = squash), asynchronous.
- key_level  output  NKEYS  debounced level, active-high (1 = held).
- key_press  output  NKEYS  one-cycle pulse on an accepted press.
- key_release  output  NKEYS  one-cycle pulse on an accepted release.
- game_sel  output  1  registered active-game select, driving the existing muxes.
- game_restart  output  1  one-cycle pulse telling the newly selected game to reset.
- switching  output  1  high throughout the guard window.

Behaviour:
- Reset (resetn low, asynchronous):
  - All outputs 0.
  - KEY synchroniser flops reset to 1 (released); mode synchroniser flops reset to 0.
  - Debounce stable states reset to "released" / 0; all counters reset to 0; FSM in IDLE.
- Release of reset is synchronous to CLOCK_50. Implementation requirement (not exercised by the bench): resetn is deasserted synchronously upstream.
- Synchronisation: every raw input passes through a 2-flop synchroniser before debouncing. KEY is inverted after synchronisation.
- Debounce (per bit):
  - State: stable value S and counter C, width $clog2(DEB_CYCLES).
  - Sample == S: C <= 0.
  - Sample != S and C < DEB_CYCLES-1: C <= C+1.
  - Sample != S and C == DEB_CYCLES-1: S <= sample, C <= 0.
- Latency: S changes on the (DEB_CYCLES+2)th rising edge after a clean raw change, counting the first edge that samples the new value.
- A glitch shorter than DEB_CYCLES synchronised cycles produces no change and no event.
- Events:
  - key_press[i] is registered and asserted in the same cycle key_level[i] first reads 1.
  - key_release[i] likewise, in the first cycle key_level[i] reads 0.
  - Each event lasts exactly 1 cycle.
- Mode FSM, states IDLE and GUARD, guard counter G:
  - IDLE, debounced mode == game_sel: stay.
  - IDLE, debounced mode != game_sel: on that edge game_sel <= debounced mode, game_restart <= 1 for one cycle, switching <= 1, G <= 0, go to GUARD.
  - GUARD: G increments each cycle. At G == GUARD_CYCLES-1, switching <= 0 and go to IDLE.
  - switching is high for exactly GUARD_CYCLES cycles.
- Suppression:
  - While switching = 1, key_press and key_release are forced to 0. Events in that window are dropped, not queued.
  - key_level continues to track debounced inputs.
  - An event on the same edge as GUARD entry is also suppressed.
- Mode changes during GUARD are ignored. On return to IDLE the mode is re-compared; if it differs, a new switch starts on the next edge, i.e. the first IDLE cycle.
- Rapid toggling never produces more than one game_restart per GUARD_CYCLES+1 cycles.
- A resetn assertion at any time, including mid-guard or mid-debounce, returns immediately to the reset state. No restart pulse is emitted on reset.

Decomposition:
- Shared package game_input_pkg:
  - Default constants DEB_CYCLES_DEF and GUARD_CYCLES_DEF.
  - Mode encoding MODE_PONG = 0, MODE_SQUASH = 1.
  - FSM state enum {IDLE, GUARD}.
- Sub-module debounce_bit: contains the synchroniser, debouncer and edge pulses, with parameter DEB_CYCLES and reset value RST_VAL. Instantiated NKEYS+1 times: one per key plus one for mode_sw.
- The top level holds the mode FSM, the guard counter and the event gating.

Test Plan (DEB_CYCLES=4, GUARD_CYCLES=8):
1. Reset: resetn=0 with KEY=4'b0000 and mode_sw=1 -> all outputs 0. After release, game_sel=1 and game_restart pulses once after 6 edges.
2. Press: KEY[0] driven 0 and held -> key_level[0]=1 and key_press[0] single pulse on the 6th edge. Later KEY[0]=1 -> key_release[0] pulse 6 edges later.
3. Glitch: KEY[2] low for 3 cycles -> key_level, key_press and key_release stay 0.
4. Switch: mode_sw 0->1 -> game_sel=1 on the 6th edge, game_restart 1-cycle pulse, switching high exactly 8 cycles. A KEY[1] press accepted inside the window -> key_level[1]=1, key_press[1]=0.
5. Re-toggle: mode_sw back to 0 during GUARD -> no change until switching falls, then on the next edge game_sel=0 with a second restart pulse.
6. Reset mid-guard: resetn=0 at G=3 -> switching=0, game_sel=0 immediately; no spurious events after release.
